// File: rtl/bus_memory_slave_if.sv
// rtl/bus_memory_slave_if.sv - Shared-bus signal bundle between the DMA master and the memory slave
interface bus_memory_slave_if;
    logic [31:0] address_dataIN;
    logic [3:0]  byte_enableIN;
    logic [7:0]  burst_sizeIN;
    logic        read_n_writeIN;
    logic        begin_transactionIN;
    logic        end_transactionIN;
    logic        data_validIN;
    logic        busyIN;
    logic [31:0] address_dataOUT;
    logic        data_validOUT;
    logic        end_transactionOUT;
    logic        busyOUT;
    logic        errorOUT;

    modport slave (
        input  address_dataIN, byte_enableIN, burst_sizeIN, read_n_writeIN,
               begin_transactionIN, end_transactionIN, data_validIN, busyIN,
        output address_dataOUT, data_validOUT, end_transactionOUT, busyOUT, errorOUT
    );

    modport master (
        output address_dataIN, byte_enableIN, burst_sizeIN, read_n_writeIN,
               begin_transactionIN, end_transactionIN, data_validIN, busyIN,
        input  address_dataOUT, data_validOUT, end_transactionOUT, busyOUT, errorOUT
    );
endinterface

// File: rtl/bus_memory_slave.sv
// rtl/bus_memory_slave.sv - Word-organised memory slave serving single-beat and burst bus transactions
// Define BUS_SLAVE_WAIT_EN for write back-pressure (busyOUT) and a 2-cycle read first-beat latency.
module bus_memory_slave #(
    parameter logic [31:0] BASE_ADDRESS = 32'h5555_5554,
    parameter int          DEPTH        = 256
) (
    input logic               clock,
    input logic               reset,
    bus_memory_slave_if.slave bus
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [29:0] BASE_WORD = BASE_ADDRESS[31:2];

`ifdef BUS_SLAVE_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, READ, WRITE, RD_END, ERR} state_t;

    state_t state, state_next;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   rdata;
    logic [AW-1:0] idx;
    logic [8:0]    count;
    logic [3:0]    be;
    logic          beat_ready;
    logic          busy_q;

    logic [29:0]   off_word;
    logic          hit;
    logic [AW-1:0] hit_idx;
    logic          accept;
    logic          consume;
    logic          last_beat;
    logic          mem_re;
    logic          mem_we;
    logic [AW-1:0] mem_raddr;

    // Base is word aligned, so the word offset can be taken on address bits [31:2] directly.
    assign off_word  = bus.address_dataIN[31:2] - BASE_WORD;
    assign hit       = off_word < 30'(DEPTH);
    assign hit_idx   = off_word[AW-1:0];
    assign last_beat = (count == 9'd1);

    assign bus.busyOUT = WAIT_EN && busy_q && (state == WRITE);
    assign accept      = (state == WRITE) && bus.data_validIN && !bus.busyOUT && (count != 9'd0);
    assign consume     = (state == READ) && beat_ready && !bus.busyIN && !bus.end_transactionIN;
    assign mem_we      = accept && !reset;

    assign bus.address_dataOUT = bus.data_validOUT ? rdata : 32'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next             = state;
        bus.data_validOUT      = 1'b0;
        bus.end_transactionOUT = 1'b0;
        bus.errorOUT           = 1'b0;
        case (state)
            IDLE: begin
                if (bus.begin_transactionIN) begin
                    if (!hit)                    state_next = ERR;
                    else if (bus.read_n_writeIN) state_next = READ;
                    else                         state_next = WRITE;
                end
            end
            READ: begin
                bus.data_validOUT = beat_ready;
                if (bus.end_transactionIN)       state_next = IDLE;
                else if (consume && last_beat)   state_next = RD_END;
            end
            WRITE: begin
                if (bus.end_transactionIN)       state_next = IDLE;
            end
            RD_END: begin
                bus.end_transactionOUT = 1'b1;
                state_next             = IDLE;
            end
            ERR: begin
                bus.errorOUT = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Read data is fetched one edge ahead so the next beat is ready when the current one is consumed.
    always_comb begin
        mem_re    = 1'b0;
        mem_raddr = idx;
        if (state == IDLE && bus.begin_transactionIN && hit && bus.read_n_writeIN && !WAIT_EN) begin
            mem_re    = 1'b1;
            mem_raddr = hit_idx;
        end else if (state == READ && !beat_ready) begin
            mem_re    = 1'b1;
        end else if (consume && !last_beat) begin
            mem_re    = 1'b1;
            mem_raddr = idx + AW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= bus.address_dataIN[8*i +: 8];
            end
        end
        if (mem_re) rdata <= mem[mem_raddr];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx        <= '0;
            count      <= 9'd0;
            be         <= 4'd0;
            beat_ready <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            busy_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.begin_transactionIN && hit) begin
                        idx        <= hit_idx;
                        count      <= {1'b0, bus.burst_sizeIN} + 9'd1;
                        be         <= bus.byte_enableIN;
                        beat_ready <= !WAIT_EN;
                    end
                end
                READ: begin
                    if (!beat_ready) begin
                        beat_ready <= 1'b1;
                    end else if (consume) begin
                        idx   <= idx + AW'(1);
                        count <= count - 9'd1;
                    end
                end
                WRITE: begin
                    busy_q <= accept;
                    if (accept) begin
                        idx   <= idx + AW'(1);
                        count <= count - 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_memory_slave.sv
// tb/tb_bus_memory_slave.sv - Self-checking bench for bus_memory_slave against a word-array reference model
module tb_bus_memory_slave;
    localparam logic [31:0] BASE  = 32'h5555_5554;
    localparam int          DEPTH = 256;
`ifdef BUS_SLAVE_WAIT_EN
    localparam bit WAIT_MODE = 1'b1;
`else
    localparam bit WAIT_MODE = 1'b0;
`endif

    typedef struct {
        bit          rnw;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        bit          exp_err;
        logic [31:0] exp;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] wq [$];
    vec_t        vt [10];

    bus_memory_slave_if bus ();

    bus_memory_slave #(.BASE_ADDRESS(BASE), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        logic [31:0] off;
        off = (addr - BASE) >> 2;
        return int'(off);
    endfunction

    task automatic check_quiet(input string name);
        check({name, "_dv"},   bus.data_validOUT, 0);
        check({name, "_dout"}, bus.address_dataOUT, 0);
        check({name, "_end"},  bus.end_transactionOUT, 0);
        check({name, "_busy"}, bus.busyOUT, 0);
        check({name, "_err"},  bus.errorOUT, 0);
    endtask

    task automatic start(input logic [31:0] addr, input logic [3:0] be, input logic [7:0] burst, input bit rnw);
        bus.begin_transactionIN = 1'b1;
        bus.address_dataIN      = addr;
        bus.byte_enableIN       = be;
        bus.burst_sizeIN        = burst;
        bus.read_n_writeIN      = rnw;
        step();
        bus.begin_transactionIN = 1'b0;
        bus.address_dataIN      = 32'd0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] be, input int burst,
                            input int nbeats, input bit end_same);
        int  w;
        bit  ended;
        bit  exp_busy;
        w = word_of(addr);
        start(addr, be, 8'(burst), 1'b0);
        for (int k = 0; k < nbeats; k++) begin
            ended                 = end_same && (k == nbeats - 1);
            bus.data_validIN      = 1'b1;
            bus.address_dataIN    = wq[k];
            bus.end_transactionIN = ended;
            step();
            if (k <= burst) model[(w + k) % DEPTH] = merge(model[(w + k) % DEPTH], wq[k], be);
            exp_busy = WAIT_MODE && (k <= burst) && !ended;
            check("wr_busy", bus.busyOUT, exp_busy);
            if (exp_busy) step();
        end
        bus.data_validIN      = 1'b0;
        bus.address_dataIN    = 32'd0;
        bus.end_transactionIN = 1'b0;
        if (!end_same) begin
            bus.end_transactionIN = 1'b1;
            step();
            bus.end_transactionIN = 1'b0;
        end
    endtask

    task automatic read_burst(input logic [31:0] addr, input int burst, input bit rnd_busy,
                              input int stall_beat, input int stall_len);
        int w, n, k, held, cyc, limit;
        bit busy;
        w = word_of(addr);
        n = burst + 1;
        limit = 4 * n + 16;
        start(addr, 4'hF, 8'(burst), 1'b1);
        if (WAIT_MODE) begin
            check("rd_lat2_dv", bus.data_validOUT, 0);
            step();
        end
        k = 0; held = 0; cyc = 0;
        while (k < n && cyc < limit) begin
            check("rd_dv", bus.data_validOUT, 1);
            check("rd_data", bus.address_dataOUT, model[(w + k) % DEPTH]);
            check("rd_end_early", bus.end_transactionOUT, 0);
            if (k == stall_beat && held < stall_len) busy = 1'b1;
            else busy = rnd_busy && ($urandom % 4 == 0);
            bus.busyIN = busy;
            step();
            if (busy) held++;
            else begin
                k++;
                held = 0;
            end
            cyc++;
        end
        bus.busyIN = 1'b0;
        if (k < n) check("rd_timeout_beats", k, n);
        check("rd_end", bus.end_transactionOUT, 1);
        check("rd_end_dv", bus.data_validOUT, 0);
        check("rd_end_dout", bus.address_dataOUT, 0);
        step();
        check("rd_end_once", bus.end_transactionOUT, 0);
    endtask

    task automatic read_one(input string name, input logic [31:0] addr, input logic [31:0] exp);
        start(addr, 4'hF, 8'd0, 1'b1);
        if (WAIT_MODE) step();
        check({name, "_dv"}, bus.data_validOUT, 1);
        check({name, "_data"}, bus.address_dataOUT, exp);
        step();
        check({name, "_end"}, bus.end_transactionOUT, 1);
        step();
    endtask

    task automatic miss(input string name, input logic [31:0] addr, input bit rnw);
        start(addr, 4'hF, 8'd3, rnw);
        check({name, "_err"}, bus.errorOUT, 1);
        check({name, "_dv"}, bus.data_validOUT, 0);
        step();
        check({name, "_err_once"}, bus.errorOUT, 0);
        check({name, "_dv2"}, bus.data_validOUT, 0);
    endtask

    initial begin
        reset                   = 1'b1;
        bus.address_dataIN      = 32'd0;
        bus.byte_enableIN       = 4'd0;
        bus.burst_sizeIN        = 8'd0;
        bus.read_n_writeIN      = 1'b0;
        bus.begin_transactionIN = 1'b0;
        bus.end_transactionIN   = 1'b0;
        bus.data_validIN        = 1'b0;
        bus.busyIN              = 1'b0;

        vt[0] = '{1'b0, 32'h5555_5554, 4'hF,    32'hDEAD_BEEF, 1'b0, 32'h0};
        vt[1] = '{1'b1, 32'h5555_5554, 4'hF,    32'h0,         1'b0, 32'hDEAD_BEEF};
        vt[2] = '{1'b0, 32'h5555_5554, 4'b0101, 32'h1122_3344, 1'b0, 32'h0};
        vt[3] = '{1'b1, 32'h5555_5554, 4'hF,    32'h0,         1'b0, 32'hDE22_BE44};
        vt[4] = '{1'b1, 32'h5555_5557, 4'hF,    32'h0,         1'b0, 32'hDE22_BE44};
        vt[5] = '{1'b1, 32'h0000_0000, 4'hF,    32'h0,         1'b1, 32'h0};
        vt[6] = '{1'b0, 32'h5555_5550, 4'hF,    32'h0,         1'b1, 32'h0};
        vt[7] = '{1'b1, 32'h5555_5954, 4'hF,    32'h0,         1'b1, 32'h0};
        vt[8] = '{1'b0, 32'h5555_5950, 4'hF,    32'hCAFE_F00D, 1'b0, 32'h0};
        vt[9] = '{1'b1, 32'h5555_5950, 4'hF,    32'h0,         1'b0, 32'hCAFE_F00D};

        step();
        step();
        check_quiet("reset");
        reset = 1'b0;
        step();

        // Fill the whole array with a 256-beat burst so every model word is known.
        wq.delete();
        for (int i = 0; i < DEPTH; i++) wq.push_back($urandom);
        do_write(BASE, 4'hF, 255, DEPTH, 1'b0);
        read_burst(BASE, 255, 1'b1, -1, 0);

        for (int i = 0; i < 10; i++) begin
            if (vt[i].exp_err) begin
                miss($sformatf("vec%0d", i), vt[i].addr, vt[i].rnw);
            end else if (vt[i].rnw) begin
                read_one($sformatf("vec%0d", i), vt[i].addr, vt[i].exp);
            end else begin
                wq.delete();
                wq.push_back(vt[i].data);
                do_write(vt[i].addr, vt[i].be, 0, 1, 1'b0);
            end
        end

        wq.delete();
        wq = '{32'd1, 32'd2, 32'd3, 32'd4};
        do_write(BASE + 32'd4 * 254, 4'hF, 3, 4, 1'b0);
        read_burst(BASE + 32'd4 * 254, 3, 1'b0, -1, 0);
        read_one("wrap_word0", BASE, 32'd3);

        read_burst(BASE + 32'd4 * 40, 2, 1'b0, 1, 3);

        // Abort an 8-beat read while beat 2 is on the bus.
        start(BASE + 32'd4 * 50, 4'hF, 8'd7, 1'b1);
        if (WAIT_MODE) step();
        for (int k = 0; k < 2; k++) begin
            check("abort_data", bus.address_dataOUT, model[50 + k]);
            step();
        end
        check("abort_beat2", bus.address_dataOUT, model[52]);
        bus.end_transactionIN = 1'b1;
        step();
        bus.end_transactionIN = 1'b0;
        check("abort_dv", bus.data_validOUT, 0);
        check("abort_end", bus.end_transactionOUT, 0);
        step();
        check("abort_end2", bus.end_transactionOUT, 0);
        check("abort_dv2", bus.data_validOUT, 0);
        read_one("after_abort", BASE + 32'd4 * 60, model[60]);

        wq.delete();
        wq = '{32'hA5A5_0001};
        do_write(BASE + 32'd4 * 30, 4'hF, 0, 1, 1'b1);
        read_one("end_same", BASE + 32'd4 * 30, 32'hA5A5_0001);

        wq.delete();
        wq = '{32'h0BAD_0001, 32'h0BAD_0002};
        do_write(BASE + 32'd4 * 20, 4'hF, 0, 2, 1'b0);
        read_burst(BASE + 32'd4 * 20, 1, 1'b0, -1, 0);

        // Reset lands on the second write beat, which must not reach memory.
        start(BASE + 32'd4 * 10, 4'hF, 8'd3, 1'b0);
        bus.data_validIN   = 1'b1;
        bus.address_dataIN = 32'h1357_9BDF;
        step();
        model[10] = 32'h1357_9BDF;
        if (WAIT_MODE) step();
        bus.address_dataIN = 32'h2468_ACE0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.data_validIN   = 1'b0;
        bus.address_dataIN = 32'd0;
        check_quiet("mid_reset");
        read_burst(BASE + 32'd4 * 10, 1, 1'b0, -1, 0);

        for (int it = 0; it < 40; it++) begin
            int          r, w, burst, extra;
            logic [31:0] addr;
            r = int'($urandom % 10);
            if (r == 0) begin
                case ($urandom % 3)
                    0:       addr = 32'd0;
                    1:       addr = BASE - 32'd4 * $urandom_range(1, 1000);
                    default: addr = BASE + 32'd4 * (DEPTH + $urandom_range(0, 1000));
                endcase
                miss("rnd_miss", addr, 1'($urandom));
            end else begin
                w     = int'($urandom % DEPTH);
                burst = int'($urandom_range(0, 15));
                addr  = BASE + 32'd4 * w + ($urandom % 4);
                if (r < 5) begin
                    extra = int'($urandom % 2);
                    wq.delete();
                    for (int i = 0; i < burst + 1 + extra; i++) wq.push_back($urandom);
                    do_write(addr, 4'($urandom), burst, burst + 1 + extra, 1'($urandom));
                end else begin
                    read_burst(addr, burst, 1'b1, -1, 0);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
